mem_arb: RTL and testbench
==========================

// Module: mem_arb
// PURPOSE
// - Two-master to one-slave memory arbiter directly downstream of the cpu's io_ifu_* and io_lsu_* ports.
// - Queues one request per master and grants them onto a single mem_* bus, one transaction at a time.
// - Routes each response back to the master that issued the request.
// - Gives LSU priority, with alternation on ties so that neither master starves.
// PARAMETERS
// - TIMEOUT_CYCLES  255  BUSY cycles without mem_respValid before forced completion; used only with MEM_ARB_TIMEOUT_EN.
// PORTS
// - clock             in   1   single clock, posedge
// - reset             in   1   asynchronous, active-low reset (0 = in reset)
// - io_ifu_reqValid   in   1   IFU request pulse; io_ifu_addr held stable until io_ifu_respValid
// - io_ifu_addr       in   32  IFU fetch address (word read)
// - io_ifu_respValid  out  1   one-cycle pulse: io_ifu_rdata valid
// - io_ifu_rdata      out  32  fetched word
// - io_lsu_reqValid   in   1   LSU request pulse; all io_lsu_* fields held stable until io_lsu_respValid
// - io_lsu_addr       in   32  LSU address
// - io_lsu_size       in   2   0=byte 1=half 2=word
// - io_lsu_wen        in   1   1=store
// - io_lsu_wdata      in   32  store data
// - io_lsu_wmask      in   4   store byte mask
// - io_lsu_respValid  out  1   one-cycle pulse: load data valid / store done
// - io_lsu_rdata      out  32  load data
// - mem_reqValid      out  1   one-cycle request pulse to memory
// - mem_addr, mem_size, mem_wen, mem_wdata, mem_wmask  out  32,2,1,32,4  registered; stable from grant until response
// - mem_respValid     in   1   memory response pulse
// - mem_rdata         in   32  memory read data, valid with mem_respValid
// - arb_err           out  1   one-cycle pulse on timeout completion
// BEHAVIOUR
// - Reset (reset==0, async):
//   - state=IDLE; ifu_pend=lsu_pend=0; last_grant=IFU, so LSU wins the first tie.
//   - Every output and every mem_* field is 0.
// - Pending flags:
//   - x_pend sets on io_x_reqValid and clears on grant to x.
//   - reqValid while x_pend=1 or while x owns the bus is a protocol violation and is ignored.
//   - Effective request: x_req = x_pend | io_x_reqValid.
// - FSM states: IDLE, BUSY_IFU, BUSY_LSU.
//   - IDLE, lsu_req only: grant LSU.
//   - IDLE, ifu_req only: grant IFU.
//   - IDLE, both: grant the master not equal to last_grant.
//   - On grant: mem_* fields registered; mem_reqValid=1 in the next cycle only; last_grant updated; state -> BUSY_x.
//   - IFU grant drives mem_size=2, mem_wen=0, mem_wmask=0, mem_wdata=0.
//   - BUSY_x, mem_respValid=1 at cycle M: io_x_respValid=1 and io_x_rdata=mem_rdata at M+1; state IDLE at M+1.
//   - Other master's pending request issues mem_reqValid at M+2 at the earliest.
// - Latency: reqValid at N in IDLE -> mem_reqValid at N+1; mem_respValid at M -> master respValid at M+1.
// - Lane handling: mem_rdata is passed unmodified (lane extraction and sign extension stay in lsu).
// - io_x_rdata holds its last value between responses; respValid outputs are never both 1 in one cycle.
// - mem_respValid in IDLE is spurious and ignored: no output changes.
// - Requests arriving during BUSY are latched in pend and served on return to IDLE.
// - Asserting reset mid-transaction aborts it; a later mem_respValid then arrives in IDLE and is dropped.
// CONFIGURATION
// - MEM_ARB_TIMEOUT_EN defined:
//   - 8-bit counter clears on grant and increments each BUSY cycle without mem_respValid.
//   - At count==TIMEOUT_CYCLES: owner gets respValid with rdata=32'hDEAD_BEEF, arb_err=1 for that cycle, state -> IDLE.
//   - A late mem_respValid then lands in IDLE and is dropped.
// - MEM_ARB_TIMEOUT_EN undefined: no counter; BUSY waits forever; arb_err tied 0; TIMEOUT_CYCLES unused.
// TESTING
// - IFU read: ifu_reqValid@0 addr=0x8000_0000.
//   - Expect mem_reqValid@1 (addr 0x8000_0000, wen=0, size=2).
//   - mem_respValid@4 rdata=0x0000_0013 -> io_ifu_respValid@5 with rdata 0x13.
// - LSU store: wen=1 size=0 addr=0x1000_0003 wdata=0xAB wmask=4'b1000.
//   - mem_* fields match exactly; io_lsu_respValid one cycle after mem_respValid; io_ifu_respValid stays 0.
// - Tie: both reqValid@0 after reset.
//   - LSU granted first (mem_reqValid@1); IFU granted next (mem_reqValid two cycles after LSU response).
//   - Repeated ties alternate IFU/LSU.
// - Queue during BUSY: lsu_reqValid during BUSY_IFU -> no second mem_reqValid until the IFU response completes.
// - Spurious/reset: mem_respValid in IDLE -> no respValid; reset=0 mid-BUSY -> all outputs 0, state IDLE.
// - Timeout (MEM_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): no mem response.
//   - Expect respValid with rdata=0xDEAD_BEEF and arb_err=1.
//   - A following grant to the same master succeeds normally.

Source files
------------

// File: rtl/mem_arb.sv
// Two-master (IFU/LSU) to one-slave memory arbiter: one request queued per master, LSU-first with tie alternation.
// Optional MEM_ARB_TIMEOUT_EN: forced completion with 32'hDEAD_BEEF and arb_err after TIMEOUT_CYCLES silent BUSY cycles.
module mem_arb #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_ifu_reqValid,
  input  logic [31:0] io_ifu_addr,
  output logic        io_ifu_respValid,
  output logic [31:0] io_ifu_rdata,
  input  logic        io_lsu_reqValid,
  input  logic [31:0] io_lsu_addr,
  input  logic [1:0]  io_lsu_size,
  input  logic        io_lsu_wen,
  input  logic [31:0] io_lsu_wdata,
  input  logic [3:0]  io_lsu_wmask,
  output logic        io_lsu_respValid,
  output logic [31:0] io_lsu_rdata,
  output logic        mem_reqValid,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_size,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_respValid,
  input  logic [31:0] mem_rdata,
  output logic        arb_err
);

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 8;

  typedef enum logic [1:0] {S_IDLE, S_BUSY_IFU, S_BUSY_LSU} state_t;

  state_t        r_state;
  logic          r_ifu_pend;
  logic          r_lsu_pend;
  logic          r_last_lsu;
  logic          r_ifu_resp;
  logic          r_lsu_resp;
  logic [DW-1:0] r_ifu_rdata;
  logic [DW-1:0] r_lsu_rdata;
  logic          r_mem_req;
  logic [AW-1:0] r_mem_addr;
  logic [1:0]    r_mem_size;
  logic          r_mem_wen;
  logic [DW-1:0] r_mem_wdata;
  logic [3:0]    r_mem_wmask;
  logic          r_err;

  logic          w_ifu_req;
  logic          w_lsu_req;
  logic          w_pick_lsu;
  logic          w_timeout;
  logic          w_done;
  logic [DW-1:0] w_resp_data;

  assign w_ifu_req  = r_ifu_pend | io_ifu_reqValid;
  assign w_lsu_req  = r_lsu_pend | io_lsu_reqValid;
  // LSU wins unless IFU also requests and LSU had the previous grant.
  assign w_pick_lsu = w_lsu_req & (~w_ifu_req | ~r_last_lsu);

`ifdef MEM_ARB_TIMEOUT_EN
  logic [CW-1:0] r_cnt;

  assign w_timeout = (r_state != S_IDLE) && !mem_respValid && (r_cnt == CW'(TIMEOUT_CYCLES));

  // Silent-cycle counter; held at zero while idle so every grant starts fresh.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (r_state == S_IDLE) begin
      r_cnt <= '0;
    end else if (!mem_respValid) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
`else
  logic [CW-1:0] w_unused_timeout;

  assign w_unused_timeout = CW'(TIMEOUT_CYCLES);
  assign w_timeout        = 1'b0;
`endif

  assign w_done      = mem_respValid | w_timeout;
  assign w_resp_data = mem_respValid ? mem_rdata : 32'hDEAD_BEEF;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_ifu_pend  <= 1'b0;
      r_lsu_pend  <= 1'b0;
      r_last_lsu  <= 1'b0;
      r_ifu_resp  <= 1'b0;
      r_lsu_resp  <= 1'b0;
      r_ifu_rdata <= '0;
      r_lsu_rdata <= '0;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_size  <= '0;
      r_mem_wen   <= 1'b0;
      r_mem_wdata <= '0;
      r_mem_wmask <= '0;
      r_err       <= 1'b0;
    end else begin
      r_ifu_resp <= 1'b0;
      r_lsu_resp <= 1'b0;
      r_mem_req  <= 1'b0;
      r_err      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_ifu_req || w_lsu_req) begin
            r_mem_req  <= 1'b1;
            r_last_lsu <= w_pick_lsu;
            r_ifu_pend <= w_ifu_req & w_pick_lsu;
            r_lsu_pend <= w_lsu_req & ~w_pick_lsu;
            if (w_pick_lsu) begin
              r_mem_addr  <= io_lsu_addr;
              r_mem_size  <= io_lsu_size;
              r_mem_wen   <= io_lsu_wen;
              r_mem_wdata <= io_lsu_wdata;
              r_mem_wmask <= io_lsu_wmask;
              r_state     <= S_BUSY_LSU;
            end else begin
              r_mem_addr  <= io_ifu_addr;
              r_mem_size  <= 2'd2;
              r_mem_wen   <= 1'b0;
              r_mem_wdata <= '0;
              r_mem_wmask <= '0;
              r_state     <= S_BUSY_IFU;
            end
          end
        end
        S_BUSY_IFU: begin
          if (io_lsu_reqValid) r_lsu_pend <= 1'b1;
          if (w_done) begin
            r_ifu_resp  <= 1'b1;
            r_ifu_rdata <= w_resp_data;
            r_err       <= w_timeout;
            r_state     <= S_IDLE;
          end
        end
        S_BUSY_LSU: begin
          if (io_ifu_reqValid) r_ifu_pend <= 1'b1;
          if (w_done) begin
            r_lsu_resp  <= 1'b1;
            r_lsu_rdata <= w_resp_data;
            r_err       <= w_timeout;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign io_ifu_respValid = r_ifu_resp;
  assign io_ifu_rdata     = r_ifu_rdata;
  assign io_lsu_respValid = r_lsu_resp;
  assign io_lsu_rdata     = r_lsu_rdata;
  assign mem_reqValid     = r_mem_req;
  assign mem_addr         = r_mem_addr;
  assign mem_size         = r_mem_size;
  assign mem_wen          = r_mem_wen;
  assign mem_wdata        = r_mem_wdata;
  assign mem_wmask        = r_mem_wmask;
  assign arb_err          = r_err;

endmodule

// File: tb/tb_mem_arb.sv
// Self-checking bench for mem_arb: vector table, directed corner sequences, and a randomized run against a transaction-level model.
module tb_mem_arb;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_ifu_reqValid = 1'b0;
  logic [31:0] io_ifu_addr = '0;
  logic        io_ifu_respValid;
  logic [31:0] io_ifu_rdata;
  logic        io_lsu_reqValid = 1'b0;
  logic [31:0] io_lsu_addr = '0;
  logic [1:0]  io_lsu_size = '0;
  logic        io_lsu_wen = 1'b0;
  logic [31:0] io_lsu_wdata = '0;
  logic [3:0]  io_lsu_wmask = '0;
  logic        io_lsu_respValid;
  logic [31:0] io_lsu_rdata;
  logic        mem_reqValid;
  logic [31:0] mem_addr;
  logic [1:0]  mem_size;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic        mem_respValid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        arb_err;

  always #5 clock = ~clock;

  mem_arb #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset),
    .io_ifu_reqValid(io_ifu_reqValid), .io_ifu_addr(io_ifu_addr),
    .io_ifu_respValid(io_ifu_respValid), .io_ifu_rdata(io_ifu_rdata),
    .io_lsu_reqValid(io_lsu_reqValid), .io_lsu_addr(io_lsu_addr),
    .io_lsu_size(io_lsu_size), .io_lsu_wen(io_lsu_wen),
    .io_lsu_wdata(io_lsu_wdata), .io_lsu_wmask(io_lsu_wmask),
    .io_lsu_respValid(io_lsu_respValid), .io_lsu_rdata(io_lsu_rdata),
    .mem_reqValid(mem_reqValid), .mem_addr(mem_addr), .mem_size(mem_size),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_respValid(mem_respValid), .mem_rdata(mem_rdata), .arb_err(arb_err)
  );

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
  } req_t;

  typedef struct {
    bit          lsu;
    logic [31:0] addr;
    logic [1:0]  size;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    int          dly;
    logic [31:0] mrdata;
    logic [1:0]  e_size;
    logic        e_wen;
    logic [31:0] e_wdata;
    logic [3:0]  e_wmask;
    logic [31:0] e_rdata;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".mem_reqValid"}, mem_reqValid, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".mem_size"}, mem_size, 0);
    chk({tag, ".mem_wen"}, mem_wen, 0);
    chk({tag, ".mem_wdata"}, mem_wdata, 0);
    chk({tag, ".mem_wmask"}, mem_wmask, 0);
    chk({tag, ".ifu_resp"}, io_ifu_respValid, 0);
    chk({tag, ".ifu_rdata"}, io_ifu_rdata, 0);
    chk({tag, ".lsu_resp"}, io_lsu_respValid, 0);
    chk({tag, ".lsu_rdata"}, io_lsu_rdata, 0);
    chk({tag, ".arb_err"}, arb_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    io_ifu_reqValid = 1'b0; io_lsu_reqValid = 1'b0; mem_respValid = 1'b0;
    repeat (2) @(negedge clock);
    chk_all_zero("rst");
    reset = 1'b1;
  endtask

  // One isolated transaction from the vector table; dly = cycles between mem_reqValid and mem_respValid.
  task automatic run_vec(input vec_t v, input int idx);
    string t;
    t = $sformatf("vec%0d", idx);
    @(negedge clock);
    io_lsu_addr = v.lsu ? v.addr : 32'h0BAD_0BAD;
    io_lsu_size = v.size; io_lsu_wen = v.wen; io_lsu_wdata = v.wdata; io_lsu_wmask = v.wmask;
    if (v.lsu) io_lsu_reqValid = 1'b1;
    else begin io_ifu_addr = v.addr; io_ifu_reqValid = 1'b1; end
    @(negedge clock);
    io_ifu_reqValid = 1'b0; io_lsu_reqValid = 1'b0;
    chk({t, ".mem_reqValid"}, mem_reqValid, 1);
    chk({t, ".mem_addr"}, mem_addr, v.addr);
    chk({t, ".mem_size"}, mem_size, v.e_size);
    chk({t, ".mem_wen"}, mem_wen, v.e_wen);
    chk({t, ".mem_wdata"}, mem_wdata, v.e_wdata);
    chk({t, ".mem_wmask"}, mem_wmask, v.e_wmask);
    for (int k = 0; k < v.dly; k++) begin
      @(negedge clock);
      chk({t, ".wait_mreq"}, mem_reqValid, 0);
      chk({t, ".wait_resp"}, {io_ifu_respValid, io_lsu_respValid}, 0);
      chk({t, ".hold_addr"}, mem_addr, v.addr);
    end
    mem_respValid = 1'b1; mem_rdata = v.mrdata;
    @(negedge clock);
    mem_respValid = 1'b0; mem_rdata = $urandom;
    chk({t, ".ifu_resp"}, io_ifu_respValid, !v.lsu);
    chk({t, ".lsu_resp"}, io_lsu_respValid, v.lsu);
    chk({t, ".rdata"}, v.lsu ? io_lsu_rdata : io_ifu_rdata, v.e_rdata);
    @(negedge clock);
    chk({t, ".resp_pulse"}, {io_ifu_respValid, io_lsu_respValid}, 0);
  endtask

  // Both masters request in the same cycle; first grant must follow the alternation rule.
  task automatic do_tie(input bit lsu_first);
    logic [31:0] ia, la, fa, sa;
    ia = 32'h8000_0100; la = 32'h0000_0200;
    fa = lsu_first ? la : ia;
    sa = lsu_first ? ia : la;
    @(negedge clock);
    io_ifu_reqValid = 1'b1; io_ifu_addr = ia;
    io_lsu_reqValid = 1'b1; io_lsu_addr = la; io_lsu_size = 2'd2; io_lsu_wen = 1'b0;
    io_lsu_wdata = '0; io_lsu_wmask = '0;
    @(negedge clock);
    io_ifu_reqValid = 1'b0; io_lsu_reqValid = 1'b0;
    chk("tie.first_mreq", mem_reqValid, 1);
    chk("tie.first_addr", mem_addr, fa);
    mem_respValid = 1'b1; mem_rdata = 32'h1111_0001;
    @(negedge clock);
    mem_respValid = 1'b0;
    chk("tie.first_resp", lsu_first ? io_lsu_respValid : io_ifu_respValid, 1);
    chk("tie.gap_mreq", mem_reqValid, 0);
    @(negedge clock);
    chk("tie.second_mreq", mem_reqValid, 1);
    chk("tie.second_addr", mem_addr, sa);
    mem_respValid = 1'b1; mem_rdata = 32'h2222_0002;
    @(negedge clock);
    mem_respValid = 1'b0;
    chk("tie.second_resp", lsu_first ? io_ifu_respValid : io_lsu_respValid, 1);
  endtask

  vec_t vecs [5];

  // Transaction-level reference state for the randomized run.
  bit          m_busy, m_owner, m_last, m_freed;
  bit          m_has [2];
  req_t        m_req [2];
  bit          exp_mreq;
  bit          exp_resp [2];
  logic [31:0] exp_rd [2];
  req_t        exp_mem;
  bit          outst [2];
  int          resp_at;
  int          p;

  initial begin
    vecs[0] = '{0, 32'h8000_0000, 2'd0, 1'b0, 32'h0, 4'h0, 3, 32'h0000_0013,
                2'd2, 1'b0, 32'h0, 4'h0, 32'h0000_0013};
    vecs[1] = '{1, 32'h1000_0003, 2'd0, 1'b1, 32'h0000_00AB, 4'b1000, 1, 32'h0,
                2'd0, 1'b1, 32'h0000_00AB, 4'b1000, 32'h0};
    vecs[2] = '{1, 32'h2000_0010, 2'd2, 1'b0, 32'h0, 4'h0, 0, 32'hCAFE_F00D,
                2'd2, 1'b0, 32'h0, 4'h0, 32'hCAFE_F00D};
    vecs[3] = '{0, 32'h8000_0004, 2'd1, 1'b1, 32'h1234_5678, 4'hF, 2, 32'hFFFF_FFFF,
                2'd2, 1'b0, 32'h0, 4'h0, 32'hFFFF_FFFF};
    vecs[4] = '{1, 32'h3000_0002, 2'd1, 1'b1, 32'hBEEF_0000, 4'b1100, 5, 32'h8765_4321,
                2'd1, 1'b1, 32'hBEEF_0000, 4'b1100, 32'h8765_4321};

    do_reset();
    do_tie(1'b1);
    for (int i = 0; i < 5; i++) run_vec(vecs[i], i);
    do_tie(1'b0);

    // LSU request while IFU owns the bus waits for the IFU response.
    @(negedge clock);
    io_ifu_reqValid = 1'b1; io_ifu_addr = 32'h8000_0200;
    @(negedge clock);
    io_ifu_reqValid = 1'b0;
    chk("q.ifu_mreq", mem_reqValid, 1);
    @(negedge clock);
    io_lsu_reqValid = 1'b1; io_lsu_addr = 32'h4000_0000; io_lsu_size = 2'd2;
    io_lsu_wen = 1'b1; io_lsu_wdata = 32'h0102_0304; io_lsu_wmask = 4'hF;
    chk("q.busy_mreq0", mem_reqValid, 0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      io_lsu_reqValid = 1'b0;
      chk("q.busy_mreq", mem_reqValid, 0);
    end
    mem_respValid = 1'b1; mem_rdata = 32'hAAAA_0001;
    @(negedge clock);
    mem_respValid = 1'b0;
    chk("q.ifu_resp", io_ifu_respValid, 1);
    chk("q.ifu_rdata", io_ifu_rdata, 32'hAAAA_0001);
    chk("q.early_mreq", mem_reqValid, 0);
    @(negedge clock);
    chk("q.lsu_mreq", mem_reqValid, 1);
    chk("q.lsu_addr", mem_addr, 32'h4000_0000);
    chk("q.lsu_wen", mem_wen, 1);
    mem_respValid = 1'b1; mem_rdata = 32'hBBBB_0002;
    @(negedge clock);
    mem_respValid = 1'b0;
    chk("q.lsu_resp", io_lsu_respValid, 1);
    chk("q.lsu_rdata", io_lsu_rdata, 32'hBBBB_0002);
    chk("q.ifu_quiet", io_ifu_respValid, 0);

    // Spurious memory response while idle changes nothing.
    @(negedge clock);
    mem_respValid = 1'b1; mem_rdata = 32'h5555_AAAA;
    @(negedge clock);
    mem_respValid = 1'b0;
    chk("spur.resp", {io_ifu_respValid, io_lsu_respValid}, 0);
    chk("spur.ifu_rdata", io_ifu_rdata, 32'hAAAA_0001);
    chk("spur.lsu_rdata", io_lsu_rdata, 32'hBBBB_0002);
    chk("spur.mreq", mem_reqValid, 0);

    // Reset mid-transaction, then the late response is dropped.
    @(negedge clock);
    io_ifu_reqValid = 1'b1; io_ifu_addr = 32'h8000_0300;
    @(negedge clock);
    io_ifu_reqValid = 1'b0;
    chk("mrst.mreq", mem_reqValid, 1);
    @(negedge clock);
    reset = 1'b0;
    #1;
    chk_all_zero("mrst");
    @(negedge clock);
    reset = 1'b1;
    mem_respValid = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clock);
    mem_respValid = 1'b0;
    chk("mrst.late_resp", io_ifu_respValid, 0);
    chk("mrst.late_rdata", io_ifu_rdata, 0);
    chk("mrst.mreq_idle", mem_reqValid, 0);
    run_vec(vecs[0], 10);

`ifdef MEM_ARB_TIMEOUT_EN
    @(negedge clock);
    io_ifu_reqValid = 1'b1; io_ifu_addr = 32'h8000_0400;
    @(negedge clock);
    io_ifu_reqValid = 1'b0;
    chk("to.mreq", mem_reqValid, 1);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clock);
      chk("to.wait_resp", io_ifu_respValid, 0);
      chk("to.wait_err", arb_err, 0);
    end
    @(negedge clock);
    chk("to.resp", io_ifu_respValid, 1);
    chk("to.rdata", io_ifu_rdata, 32'hDEAD_BEEF);
    chk("to.err", arb_err, 1);
    mem_respValid = 1'b1; mem_rdata = 32'h9999_9999;
    @(negedge clock);
    mem_respValid = 1'b0;
    chk("to.err_pulse", arb_err, 0);
    chk("to.late_drop", io_ifu_respValid, 0);
    chk("to.rdata_hold", io_ifu_rdata, 32'hDEAD_BEEF);
    run_vec(vecs[3], 11);
`endif

    // Randomized traffic against the transaction-level model.
    do_reset();
    m_busy = 0; m_owner = 0; m_last = 0;
    m_has = '{0, 0}; outst = '{0, 0};
    exp_mreq = 0; exp_resp = '{0, 0}; exp_rd = '{32'h0, 32'h0};
    exp_mem = '{32'h0, 2'd0, 1'b0, 32'h0, 4'h0};
    m_req[0] = exp_mem; m_req[1] = exp_mem;
    resp_at = -1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      chk("rnd.mreq", mem_reqValid, exp_mreq);
      chk("rnd.ifu_resp", io_ifu_respValid, exp_resp[0]);
      chk("rnd.lsu_resp", io_lsu_respValid, exp_resp[1]);
      chk("rnd.ifu_rdata", io_ifu_rdata, exp_rd[0]);
      chk("rnd.lsu_rdata", io_lsu_rdata, exp_rd[1]);
      chk("rnd.mem_fields", {mem_addr, mem_size, mem_wen, mem_wmask},
          {exp_mem.addr, exp_mem.size, exp_mem.wen, exp_mem.wmask});
      chk("rnd.mem_wdata", mem_wdata, exp_mem.wdata);
      chk("rnd.arb_err", arb_err, 0);
      if (io_ifu_respValid) outst[0] = 0;
      if (io_lsu_respValid) outst[1] = 0;
      if (mem_reqValid) resp_at = c + 1 + int'($urandom_range(0, 3));
      mem_respValid = (c == resp_at);
      mem_rdata = $urandom;
      if (c == resp_at) resp_at = -1;
      io_ifu_reqValid = 1'b0;
      io_lsu_reqValid = 1'b0;
      if (!outst[0] && ($urandom_range(0, 3) == 0)) begin
        io_ifu_reqValid = 1'b1; io_ifu_addr = $urandom; outst[0] = 1;
        m_req[0] = '{io_ifu_addr, 2'd2, 1'b0, 32'h0, 4'h0};
      end
      if (!outst[1] && ($urandom_range(0, 3) == 0)) begin
        io_lsu_reqValid = 1'b1; io_lsu_addr = $urandom;
        io_lsu_size = 2'($urandom_range(0, 2)); io_lsu_wen = 1'($urandom);
        io_lsu_wdata = $urandom; io_lsu_wmask = 4'($urandom);
        outst[1] = 1;
        m_req[1] = '{io_lsu_addr, io_lsu_size, io_lsu_wen, io_lsu_wdata, io_lsu_wmask};
      end
      // Model: bus occupied until the response cycle; the next grant comes from the cycle after.
      exp_mreq = 0; exp_resp = '{0, 0}; m_freed = 0;
      if (m_busy && mem_respValid) begin
        exp_resp[m_owner] = 1; exp_rd[m_owner] = mem_rdata;
        m_busy = 0; m_freed = 1;
      end
      if (io_ifu_reqValid) m_has[0] = 1;
      if (io_lsu_reqValid) m_has[1] = 1;
      if (!m_busy && !m_freed && (m_has[0] || m_has[1])) begin
        p = (m_has[0] && m_has[1]) ? int'(!m_last) : int'(m_has[1]);
        exp_mreq = 1; exp_mem = m_req[p];
        m_has[p] = 0; m_last = p[0]; m_owner = p[0]; m_busy = 1;
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
